// File: rtl/seg_pkg.sv
// Shared constants for the eight-digit doorbell status display scanner.
// Holds the glyph table, cathode-off pattern, decoder codes and parameter defaults.
package seg_pkg;

    localparam int SCAN_DIV_DEF  = 62500;
    localparam int GAP_DEF       = 2500;
    localparam int BLINK_DIV_DEF = 12500000;

    localparam logic [7:0] CAT_OFF = 8'hFF;

    localparam logic [7:0] GLYPH_0     = 8'h3f;
    localparam logic [7:0] GLYPH_1     = 8'h06;
    localparam logic [7:0] GLYPH_2     = 8'h5b;
    localparam logic [7:0] GLYPH_3     = 8'h4f;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'h6d;
    localparam logic [7:0] GLYPH_6     = 8'h7d;
    localparam logic [7:0] GLYPH_7     = 8'h07;
    localparam logic [7:0] GLYPH_8     = 8'h7f;
    localparam logic [7:0] GLYPH_9     = 8'h6f;
    localparam logic [7:0] GLYPH_DASH  = 8'h40;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [2:0] MODE_MAX = 3'd4;
    localparam logic [2:0] TRCK_MAX = 3'd5;

    // Valid codes 1..hi show as their digit; anything else shows a dash.
    function automatic logic [3:0] range_code(input logic [2:0] v, input logic [2:0] hi);
        return ((v != 3'd0) && (v <= hi)) ? {1'b0, v} : CODE_DASH;
    endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-side signal bundle of the scanner: doorbell status inputs and LED drive outputs.
interface seg_scan_if;
    logic [2:0] MODE;
    logic [2:0] TRCK;
    logic       LOCK;
    logic [7:0] SEG;
    logic [7:0] CAT;

    modport master (output MODE, output TRCK, output LOCK, input SEG, input CAT);
    modport slave  (input MODE, input TRCK, input LOCK, output SEG, output CAT);
endinterface

// File: rtl/seg_dec.sv
// Seven-segment glyph decoder: code 0..9 digits, 10 dash, anything else blank.
module seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] code,
    output logic [7:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (code)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            4'd10:   seg = GLYPH_DASH;
            default: seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed LED scanner: mode on digit0, track on digit2, ring count on 4..7.
// SEG_RING_CNT_EN enables the ring counter, its blink and digits 4..7; otherwise they stay dark.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int GAP       = GAP_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic      CLK,
    input  logic      RST_N,
    seg_scan_if.slave bus
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [SW-1:0] slot_cnt;
    logic [SW-1:0] slot_nxt;
    logic [2:0]    dig_idx;
    logic [2:0]    dig_nxt;
    logic          slot_wrap;
    logic          frame_wrap;
    logic [2:0]    mode_r;
    logic [2:0]    trck_r;
    logic [2:0]    mode_nxt;
    logic [2:0]    trck_nxt;
    logic [3:0]    code;
    logic [7:0]    glyph;
    logic          lit;

    // Outputs are computed from next-state values so SEG and CAT switch together.
    always_comb begin
        slot_wrap  = (slot_cnt == SLOT_LAST);
        frame_wrap = slot_wrap && (dig_idx == 3'd7);
        slot_nxt   = slot_wrap ? '0 : slot_cnt + SW'(1);
        dig_nxt    = slot_wrap ? dig_idx + 3'd1 : dig_idx;
        mode_nxt   = frame_wrap ? bus.MODE : mode_r;
        trck_nxt   = frame_wrap ? bus.TRCK : trck_r;
    end

`ifdef SEG_RING_CNT_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic            lock_q;
    logic            rise;
    logic            carry;
    logic            blink_ph;
    logic            blink_ph_nxt;
    logic            hide;
    logic [BW-1:0]   blink_cnt;
    logic [BW-1:0]   blink_cnt_nxt;
    logic [3:0][3:0] cnt;
    logic [3:0][3:0] cnt_inc;
    logic [3:0][3:0] disp_cnt;
    logic [3:0][3:0] disp_cnt_nxt;

    always_comb begin
        rise    = bus.LOCK & ~lock_q;
        carry   = 1'b1;
        cnt_inc = cnt;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (cnt[i] == 4'd9) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end

        blink_cnt_nxt = blink_cnt + BW'(1);
        blink_ph_nxt  = blink_ph;
        if (rise) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_nxt = '0;
            blink_ph_nxt  = ~blink_ph;
        end

        hide         = bus.LOCK & blink_ph_nxt;
        // The count is sampled before this cycle's increment, so a coincident edge shows next frame.
        disp_cnt_nxt = frame_wrap ? cnt : disp_cnt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lock_q    <= 1'b0;
            cnt       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            disp_cnt  <= '0;
        end else begin
            lock_q    <= bus.LOCK;
            blink_cnt <= blink_cnt_nxt;
            blink_ph  <= blink_ph_nxt;
            disp_cnt  <= disp_cnt_nxt;
            if (rise) begin
                cnt <= cnt_inc;
            end
        end
    end
`endif

    always_comb begin
        code = CODE_BLANK;
        case (dig_nxt)
            3'd0: code = range_code(mode_nxt, MODE_MAX);
            3'd2: code = range_code(trck_nxt, TRCK_MAX);
`ifdef SEG_RING_CNT_EN
            3'd4: code = (disp_cnt_nxt[3] != 4'd0) ? disp_cnt_nxt[3] : CODE_BLANK;
            3'd5: code = (disp_cnt_nxt[3:2] != '0) ? disp_cnt_nxt[2] : CODE_BLANK;
            3'd6: code = (disp_cnt_nxt[3:1] != '0) ? disp_cnt_nxt[1] : CODE_BLANK;
            3'd7: code = disp_cnt_nxt[0];
`endif
            default: code = CODE_BLANK;
        endcase
`ifdef SEG_RING_CNT_EN
        if (dig_nxt[2] && hide) begin
            code = CODE_BLANK;
        end
`endif
        // Blank digits keep their cathode off, not just their segments.
        lit = (int'(slot_nxt) >= GAP) && (code != CODE_BLANK);
    end

    seg_dec u_dec (
        .code (code),
        .seg  (glyph)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            mode_r   <= '0;
            trck_r   <= '0;
            bus.SEG  <= GLYPH_BLANK;
            bus.CAT  <= CAT_OFF;
        end else begin
            slot_cnt <= slot_nxt;
            dig_idx  <= dig_nxt;
            mode_r   <= mode_nxt;
            trck_r   <= trck_nxt;
            bus.SEG  <= lit ? glyph : GLYPH_BLANK;
            bus.CAT  <= lit ? ~(8'd1 << dig_nxt) : CAT_OFF;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: random status inputs and LOCK pulses against a cycle-indexed display model.
`timescale 1ns/1ps
module tb_seg_scan;

    localparam int S     = 8;
    localparam int G     = 2;
    localparam int B     = 64;
    localparam int FRAME = 8 * S;
`ifdef SEG_RING_CNT_EN
    localparam bit RING = 1'b1;
`else
    localparam bit RING = 1'b0;
`endif
    localparam logic [7:0] GL [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66,
                                       8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    seg_scan_if bus ();

    seg_scan #(.SCAN_DIV(S), .GAP(G), .BLINK_DIV(B)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   t         = 0;
    int   rises     = 0;
    int   last_rise = 0;
    logic prev_lock = 1'b0;
    int   smode     = 0;
    int   strck     = 0;
    int   scnt      = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0d: got %02h, expected %02h", tag, t, got, exp);
        end
    endtask

    // Glyph a digit should show from the frame's sampled values, or 0 when dark.
    function automatic logic [7:0] exp_digit(input int d, input int m, input int tr,
                                             input int n, input bit hide);
        logic [7:0] g;
        g = 8'h00;
        case (d)
            0: g = (m >= 1 && m <= 4) ? GL[m] : 8'h40;
            2: g = (tr >= 1 && tr <= 5) ? GL[tr] : 8'h40;
            4: if (RING && !hide && n >= 1000) g = GL[n / 1000];
            5: if (RING && !hide && n >= 100)  g = GL[(n / 100) % 10];
            6: if (RING && !hide && n >= 10)   g = GL[(n / 10) % 10];
            7: if (RING && !hide)              g = GL[n % 10];
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Model: t counts clock edges since reset release; slot/digit/frame follow by division.
    initial begin : model_checker
        forever begin
            @(posedge CLK);
            if (!RST_N) begin
                t = 0; rises = 0; last_rise = 0; prev_lock = 1'b0;
                smode = 0; strck = 0; scnt = 0;
                #1;
                check_val("reset_seg", bus.SEG, 8'h00);
                check_val("reset_cat", bus.CAT, 8'hff);
            end else begin
                logic       lk;
                int         slot;
                int         dig;
                bit         hide;
                logic [7:0] g;
                logic [7:0] es;
                logic [7:0] ec;
                t++;
                lk = bus.LOCK;
                if (t % FRAME == 0) begin
                    smode = int'(bus.MODE);
                    strck = int'(bus.TRCK);
                    scnt  = rises % 10000;
                end
                if (lk && !prev_lock) begin
                    rises++;
                    last_rise = t;
                end
                prev_lock = lk;
                slot = t % S;
                dig  = (t / S) % 8;
                hide = lk && (((t - last_rise) / B) % 2 == 1);
                g    = exp_digit(dig, smode, strck, scnt, hide);
                if (slot >= G && g != 8'h00) begin
                    es = g;
                    ec = ~(8'd1 << dig);
                end else begin
                    es = 8'h00;
                    ec = 8'hff;
                end
                #1;
                check_val($sformatf("seg_d%0d", dig), bus.SEG, es);
                check_val($sformatf("cat_d%0d", dig), bus.CAT, ec);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.LOCK = 1'b1;
        cyc(hi);
        bus.LOCK = 1'b0;
        cyc(lo);
    endtask

    task automatic align_wrap();
        for (int i = 0; i < FRAME + 2; i++) begin
            if ((t + 1) % FRAME == 0) break;
            cyc(1);
        end
    endtask

    initial begin : stimulus
        bus.MODE = 3'd1;
        bus.TRCK = 3'd3;
        bus.LOCK = 1'b0;
        RST_N    = 1'b0;
        cyc(3);
        RST_N = 1'b1;
        cyc(3 * FRAME);

        for (int i = 0; i < 6 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.MODE = 3'($urandom_range(0, 7));
                bus.TRCK = 3'($urandom_range(0, 7));
            end
            cyc(1);
        end

        align_wrap();
        cyc(FRAME / 2);
        bus.MODE = 3'd0;
        bus.TRCK = 3'd7;
        cyc(2 * FRAME);
        bus.MODE = 3'd4;
        bus.TRCK = 3'd5;

        for (int i = 0; i < 12; i++) begin
            pulse((i == 5) ? 3 : int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        end
        cyc(2 * FRAME);

        bus.LOCK = 1'b1;
        cyc(256);
        bus.LOCK = 1'b0;
        cyc(2 * FRAME);

        for (int i = rises; i < 9999; i++) pulse(1, 1);
        cyc(2 * FRAME);
        pulse(1, 1);
        cyc(2 * FRAME);

        // First of these edges lands exactly on a frame wrap.
        align_wrap();
        pulse(2, 2);
        for (int i = 0; i < 122; i++) begin
            pulse(int'($urandom_range(1, 2)), int'($urandom_range(1, 2)));
        end
        cyc(2 * FRAME);

        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((t / S) % 8 == 5 && t % S == 3) break;
            cyc(1);
        end
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check_val("async_seg", bus.SEG, 8'h00);
        check_val("async_cat", bus.CAT, 8'hff);
        cyc(3);
        RST_N = 1'b1;
        cyc(2 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
